// File: rtl/data_memory.sv
// MEM-stage load/store data memory: byte/half/word stores through byte-lane
// enables, synchronous-read RAM, one-cycle stall per load, misalignment trap.
module data_memory #(
   parameter int ADDR_WIDTH = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        wen,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        requireStall,
   output logic        exception
);

   typedef enum logic {IDLE, DATA} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t                  state, state_nxt;
   logic [1:0]              lat_off;
   logic [1:0]              lat_size;
   logic                    lat_sign;
   logic [ADDR_WIDTH-1:0]   word_idx;
   logic [3:0]              lane_we;
   logic [31:0]             wdata;
   logic [31:0]             rdata;
   logic                    rd_issue;
   logic                    wr_issue;
   logic [7:0]              ld_byte;
   logic [15:0]             ld_half;
   logic                    unused_addr_hi;

   logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

   // High address bits are dropped on purpose: out-of-range addresses alias.
   assign word_idx       = addr[ADDR_WIDTH+1:2];
   assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      exception = 1'b0;
      if (en) begin
         case (size)
            SZ_BYTE: exception = 1'b0;
            SZ_HALF: exception = addr[0];
            SZ_WORD: exception = |addr[1:0];
            default: exception = 1'b1;
         endcase
      end
   end

   // Accesses start only from IDLE and never while reset is held.
   assign rd_issue     = rst && en && !wen && !exception && (state == IDLE);
   assign wr_issue     = rst && en &&  wen && !exception && (state == IDLE);
   assign requireStall = rd_issue;

   always_comb begin
      lane_we = 4'b0000;
      wdata   = din;
      if (wr_issue) begin
         case (size)
            SZ_BYTE: begin
               lane_we = 4'b0001 << addr[1:0];
               wdata   = {4{din[7:0]}};
            end
            SZ_HALF: begin
               lane_we = addr[1] ? 4'b1100 : 4'b0011;
               wdata   = {2{din[15:0]}};
            end
            default: begin
               lane_we = 4'b1111;
               wdata   = din;
            end
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rd_issue) state_nxt = DATA;
         DATA:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         lat_off  <= 2'b00;
         lat_size <= 2'b00;
         lat_sign <= 1'b0;
      end else begin
         state <= state_nxt;
         if (rd_issue) begin
            lat_off  <= addr[1:0];
            lat_size <= size;
            lat_sign <= sign;
         end
      end
   end

   // NOTE: the RAM array and its read register carry no reset; contents survive rst.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (lane_we[k]) mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
      end
      if (rd_issue) rdata <= mem[word_idx];
   end

   assign ld_byte = rdata[8*lat_off +: 8];
   assign ld_half = lat_off[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      dout = 32'h0;
      if (state == DATA && !exception) begin
         case (lat_size)
            SZ_BYTE: dout = {{24{lat_sign & ld_byte[7]}}, ld_byte};
            SZ_HALF: dout = {{16{lat_sign & ld_half[15]}}, ld_half};
            SZ_WORD: dout = rdata;
            default: dout = 32'h0;
         endcase
      end
   end

endmodule
